// File: rtl/asg_dac_slew_ctrl.sv
// Slew-rate limiter and park/release sequencer between an ASG channel and its DAC pins.
// Keeps the analog output free of steps when a channel is armed, disabled or parked.
module asg_dac_slew_ctrl #(
  parameter int DW   = 14,
  parameter int DIVW = 16
) (
  input  logic            dac_clk_i,
  input  logic            dac_rst_i,
  input  logic [DW-1:0]   dat_i,
  input  logic            set_en_i,
  input  logic            set_park_i,
  input  logic [DW-1:0]   set_park_val_i,
  input  logic [DW-1:0]   set_step_i,
  input  logic [DIVW-1:0] set_div_i,
  input  logic            clr_cnt_i,
  output logic [DW-1:0]   dac_o,
  output logic            slewing_o,
  output logic            parked_o,
  output logic [31:0]     lim_cnt_o
);

  typedef enum logic [1:0] {
    ST_BYPASS  = 2'd0,
    ST_TRACK   = 2'd1,
    ST_PARK    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   dac_q, dac_d;
  logic            slew_q, slew_d;
  logic            parked_q, parked_d;
  logic [31:0]     lim_q, lim_d;
  logic [DIVW-1:0] div_q, div_d;

  logic            tick;
  logic [DW-1:0]   target;
  logic [DW:0]     dac_ext, diff, abs_diff, step_ext, stepped;
  logic            limited;
  logic [DW-1:0]   slew_val;

  // All magnitude work is done one bit wider so full-scale swings cannot wrap.
  always_comb begin
    tick     = (div_q == '0);
    div_d    = tick ? set_div_i : div_q - DIVW'(1);
    target   = (state_q == ST_PARK) ? set_park_val_i : dat_i;
    dac_ext  = {dac_q[DW-1], dac_q};
    diff     = {target[DW-1], target} - dac_ext;
    abs_diff = diff[DW] ? (~diff + (DW+1)'(1)) : diff;
    step_ext = {1'b0, set_step_i};
    limited  = (abs_diff > step_ext);
    stepped  = diff[DW] ? (dac_ext - step_ext) : (dac_ext + step_ext);
    slew_val = limited ? stepped[DW-1:0] : target;
  end

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    slew_d  = slew_q;
    case (state_q)
      ST_BYPASS: begin
        dac_d  = dat_i;
        slew_d = 1'b0;
        if (set_park_i)    state_d = ST_PARK;
        else if (set_en_i) state_d = ST_TRACK;
      end
      default: begin
        if (tick) begin
          dac_d  = slew_val;
          slew_d = limited;
        end
        case (state_q)
          ST_TRACK: begin
            if (set_park_i)     state_d = ST_PARK;
            else if (!set_en_i) state_d = ST_RELEASE;
          end
          ST_PARK: begin
            if (!set_park_i) state_d = set_en_i ? ST_TRACK : ST_RELEASE;
          end
          default: begin
            if (set_park_i)              state_d = ST_PARK;
            else if (set_en_i)           state_d = ST_TRACK;
            else if (tick && !limited)   state_d = ST_BYPASS;
          end
        endcase
      end
    endcase
  end

  // parked lags the output by one cycle and drops as soon as PARK is left.
  always_comb begin
    parked_d = (state_q == ST_PARK) && (state_d == ST_PARK) && (dac_q == set_park_val_i);
    lim_d    = lim_q;
    if (clr_cnt_i)
      lim_d = '0;
    else if (tick && (state_q != ST_BYPASS) && limited && (lim_q != 32'hFFFF_FFFF))
      lim_d = lim_q + 32'd1;
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q  <= ST_BYPASS;
      dac_q    <= '0;
      slew_q   <= 1'b0;
      parked_q <= 1'b0;
      lim_q    <= '0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      slew_q   <= slew_d;
      parked_q <= parked_d;
      lim_q    <= lim_d;
      div_q    <= div_d;
    end
  end

  assign dac_o     = dac_q;
  assign slewing_o = slew_q;
  assign parked_o  = parked_q;
  assign lim_cnt_o = lim_q;

endmodule

// File: tb/tb_asg_dac_slew_ctrl.sv
// Scenario bench for asg_dac_slew_ctrl: expected samples are queued as stimulus is
// driven and compared against captured outputs at the end of each scenario.
module tb_asg_dac_slew_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] dat, pval, stepv;
  logic        en, park, clr;
  logic [15:0] div;
  logic [13:0] dac_o;
  logic        slewing_o, parked_o;
  logic [31:0] lim_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [13:0] dac;
    logic        slew;
    logic        park;
    logic [31:0] lim;
  } smp_t;

  smp_t exp_q[$];
  smp_t obs_q[$];

  always #5 clk = ~clk;

  asg_dac_slew_ctrl #(.DW(14), .DIVW(16)) dut (
    .dac_clk_i(clk), .dac_rst_i(rst), .dat_i(dat), .set_en_i(en),
    .set_park_i(park), .set_park_val_i(pval), .set_step_i(stepv),
    .set_div_i(div), .clr_cnt_i(clr), .dac_o(dac_o), .slewing_o(slewing_o),
    .parked_o(parked_o), .lim_cnt_o(lim_cnt_o)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Queue the expected sample, advance one clock and capture what the DUT shows.
  task automatic step(input int edac, input bit esl, input bit epk, input logic [31:0] elim);
    smp_t e, o;
    e.dac = 14'(edac); e.slew = esl; e.park = epk; e.lim = elim;
    exp_q.push_back(e);
    @(posedge clk); #1;
    o.dac = dac_o; o.slew = slewing_o; o.park = parked_o; o.lim = lim_cnt_o;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    smp_t e, o;
    int n = 0;
    rst = 1'b1; dat = '0; en = 0; park = 0; pval = '0; stepv = '0; div = '0; clr = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d] got dac=%0d slew=%b parked=%b lim=%h want dac=%0d slew=%b parked=%b lim=%h",
                 n, $signed(o.dac), o.slew, o.park, o.lim, $signed(e.dac), e.slew, e.park, e.lim);
      end
      n++;
    end
  endtask

  task automatic test_bypass();
    smp_t e, o;
    int n = 0;
    for (int i = 0; i <= 100; i++) begin
      dat = 14'(i);
      step(i, 0, 0, 0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bypass[%0d] got dac=%0d slew=%b parked=%b lim=%h want dac=%0d slew=%b parked=%b lim=%h",
                 n, $signed(o.dac), o.slew, o.park, o.lim, $signed(e.dac), e.slew, e.park, e.lim);
      end
      n++;
    end
  endtask

  task automatic test_track_slew();
    smp_t e, o;
    int n = 0;
    dat = '0;
    step(0, 0, 0, 0);
    en = 1; stepv = 14'd100;
    step(0, 0, 0, 0);
    dat = 14'd1000;
    for (int k = 1; k <= 10; k++) step(100 * k, k < 10, 0, (k < 9) ? k : 9);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL track_slew[%0d] got dac=%0d slew=%b parked=%b lim=%h want dac=%0d slew=%b parked=%b lim=%h",
                 n, $signed(o.dac), o.slew, o.park, o.lim, $signed(e.dac), e.slew, e.park, e.lim);
      end
      n++;
    end
  endtask

  task automatic test_divider();
    smp_t e, o;
    int n = 0;
    dat = '0; stepv = 14'd16383; div = 16'd3;
    step(0, 0, 0, 9);
    stepv = 14'd50; dat = 14'(-200);
    for (int k = 1; k <= 16; k++)
      step(-50 * (k / 4), (k >= 4) && (k < 16), 0, 9 + (((k / 4) < 3) ? (k / 4) : 3));
    div = 16'd0;
    for (int k = 17; k <= 20; k++) step(-200, 0, 0, 12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL divider[%0d] got dac=%0d slew=%b parked=%b lim=%h want dac=%0d slew=%b parked=%b lim=%h",
                 n, $signed(o.dac), o.slew, o.park, o.lim, $signed(e.dac), e.slew, e.park, e.lim);
      end
      n++;
    end
  endtask

  task automatic test_park_fullscale();
    smp_t e, o;
    int n = 0;
    stepv = 14'd16383; dat = 14'd8191;
    step(8191, 0, 0, 12);
    park = 1; pval = 14'(-8192);
    step(8191, 0, 0, 12);
    step(-8192, 0, 0, 12);
    step(-8192, 0, 1, 12);
    park = 0;
    step(-8192, 0, 0, 12);
    step(8191, 0, 0, 12);
    park = 1; stepv = 14'd4096;
    step(8191, 0, 0, 12);
    step(4095, 1, 0, 13);
    step(-1, 1, 0, 14);
    step(-4097, 1, 0, 15);
    step(-8192, 0, 0, 15);
    step(-8192, 0, 1, 15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL park_fullscale[%0d] got dac=%0d slew=%b parked=%b lim=%h want dac=%0d slew=%b parked=%b lim=%h",
                 n, $signed(o.dac), o.slew, o.park, o.lim, $signed(e.dac), e.slew, e.park, e.lim);
      end
      n++;
    end
  endtask

  task automatic test_release();
    smp_t e, o;
    int n = 0;
    int d;
    logic [13:0] prev;
    pval = '0; stepv = 14'd16383;
    step(0, 0, 0, 15);
    step(0, 0, 1, 15);
    en = 0; dat = 14'd300; stepv = 14'd100; park = 0;
    step(0, 0, 0, 15);
    step(100, 1, 0, 16);
    step(200, 1, 0, 17);
    step(300, 0, 0, 17);
    step(300, 0, 0, 17);
    dat = 14'd310;
    step(310, 0, 0, 17);
    dat = 14'd390;
    step(390, 0, 0, 17);
    prev = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL release[%0d] got dac=%0d slew=%b parked=%b lim=%h want dac=%0d slew=%b parked=%b lim=%h",
                 n, $signed(o.dac), o.slew, o.park, o.lim, $signed(e.dac), e.slew, e.park, e.lim);
      end
      d = int'($signed(o.dac)) - int'($signed(prev));
      checks++;
      if (d > 100 || d < -100) begin
        errors++;
        $display("FAIL release_step[%0d] got output step %0d want |step| <= 100", n, d);
      end
      prev = o.dac;
      n++;
    end
  endtask

  task automatic test_reset_mid_ramp();
    smp_t e, o;
    int n = 0;
    dat = 14'd320; en = 1; stepv = 14'd10;
    step(320, 0, 0, 17);
    dat = 14'd1000;
    step(330, 1, 0, 18);
    step(340, 1, 0, 19);
    rst = 1; en = 0;
    step(0, 0, 0, 0);
    rst = 0;
    step(1000, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_ramp[%0d] got dac=%0d slew=%b parked=%b lim=%h want dac=%0d slew=%b parked=%b lim=%h",
                 n, $signed(o.dac), o.slew, o.park, o.lim, $signed(e.dac), e.slew, e.park, e.lim);
      end
      n++;
    end
  endtask

  task automatic test_counter_clr_sat();
    smp_t e, o;
    int n = 0;
    en = 1; stepv = '0;
    step(1000, 0, 0, 0);
    dat = 14'd500;
    step(1000, 1, 0, 1);
    step(1000, 1, 0, 2);
    clr = 1;
    step(1000, 1, 0, 0);
    clr = 0;
    step(1000, 1, 0, 1);
    force dut.lim_q = 32'hFFFF_FFFE;
    step(1000, 1, 0, 32'hFFFF_FFFE);
    release dut.lim_q;
    step(1000, 1, 0, 32'hFFFF_FFFF);
    step(1000, 1, 0, 32'hFFFF_FFFF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL counter_clr_sat[%0d] got dac=%0d slew=%b parked=%b lim=%h want dac=%0d slew=%b parked=%b lim=%h",
                 n, $signed(o.dac), o.slew, o.park, o.lim, $signed(e.dac), e.slew, e.park, e.lim);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_track_slew();
    test_divider();
    test_park_fullscale();
    test_release();
    test_reset_mid_ramp();
    test_counter_clr_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
